ext_mem_responder: RTL

Memory-side responder for the accelerator's external memory interface. The accelerator issues read and write requests using rvalid/raddr and wvalid/waddr/wdata; this block completes them with rready/rdata and wready. It serves those requests from a single-port synchronous SRAM with a fixed read latency. It is used as the on-chip backing store in FPGA builds and as the memory model in block- and system-level benches.

---
 rtl/ext_mem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ext_mem_responder.sv
// Completes valid/ready read and write requests from a single-port synchronous SRAM, one transaction at a time.
// Writes take 1 cycle to wready; reads take READ_LATENCY+2 cycles to rready; stall blocks acceptance in IDLE.
module ext_mem_responder #(
    parameter int AW           = 26,
    parameter int DW           = 32,
    parameter int MEM_AW       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wvalid,
    output logic              wready,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              rvalid,
    output logic              rready,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdata,
    input  logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              err,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRESP  = 3'd1,
        RISSUE = 3'd2,
        RWAIT  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] lat_cnt;
    logic          rd_oor;
    logic          w_oor;
    logic          r_oor;

    // Any address bit above the SRAM range marks the request out of range.
    generate
        if (AW > MEM_AW) begin : g_range
            assign w_oor = |waddr[AW-1:MEM_AW];
            assign r_oor = |raddr[AW-1:MEM_AW];
        end else begin : g_norange
            assign w_oor = 1'b0;
            assign r_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rd_oor    <= 1'b0;
            wready    <= 1'b0;
            rready    <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            // Pulsed outputs default low; only the cycle that owns them raises them.
            wready <= 1'b0;
            rready <= 1'b0;
            rdata  <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (!stall) begin
                        if (wvalid) begin
                            state     <= WRESP;
                            wready    <= 1'b1;
                            mem_en    <= !w_oor;
                            mem_we    <= !w_oor;
                            mem_addr  <= waddr[MEM_AW-1:0];
                            mem_wdata <= wdata;
                            wr_count  <= wr_count + 32'd1;
                            if (w_oor) begin
                                err <= 1'b1;
                            end
                        end else if (rvalid) begin
                            state    <= RISSUE;
                            mem_en   <= !r_oor;
                            mem_addr <= raddr[MEM_AW-1:0];
                            rd_oor   <= r_oor;
                            if (r_oor) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end

                WRESP: begin
                    state <= IDLE;
                end

                RISSUE: begin
                    state   <= RWAIT;
                    lat_cnt <= LAT_LAST;
                end

                RWAIT: begin
                    // Last wait cycle is when the SRAM word is valid on mem_rdata.
                    if (lat_cnt == '0) begin
                        state    <= RRESP;
                        rready   <= 1'b1;
                        rdata    <= rd_oor ? '0 : mem_rdata;
                        rd_count <= rd_count + 32'd1;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end

                RRESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
